// File: rtl/rf_pkg.sv
// Shared defaults and address type for the ID-stage integer register file.
package rf_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef logic [AW-1:0] rf_addr_t;

  localparam rf_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set by issue, cleared by writeback; set wins on a collision.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = rf_pkg::NREG,
  parameter int AW   = rf_pkg::AW,
  parameter int NWR  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic [NREG-1:0]   busy
);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++)
      if (we[j]) busy_d[wr_addr[j*AW +: AW]] = 1'b0;
    // Applied after the clears so a new producer supersedes the retiring one.
    if (iss_valid && iss_rd != '0) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/id_rf_mp.sv
// Multi-port register file with write priority, optional write-to-read bypass and busy masking.
module id_rf_mp
  import rf_pkg::*;
#(
  parameter int XLEN   = rf_pkg::XLEN,
  parameter int NREG   = rf_pkg::NREG,
  parameter int AW     = rf_pkg::AW,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd
);

  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREG-1:0]           busy;

  // Ascending port order: the highest-index writer to an address lands last.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++)
      if (we[j] && wr_addr[j*AW +: AW] != '0)
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  rf_scoreboard #(.NREG(NREG), .AW(AW), .NWR(NWR)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wr_addr  (wr_addr),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .busy     (busy)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic            hit;
    logic            use_byp;
    logic [XLEN-1:0] byp_d;

    assign a = rs_addr[i*AW +: AW];

    always_comb begin
      hit   = 1'b0;
      byp_d = '0;
      for (int j = 0; j < NWR; j++)
        if (we[j] && wr_addr[j*AW +: AW] == a) begin
          hit   = 1'b1;
          byp_d = wr_data[j*XLEN +: XLEN];
        end
    end

    assign use_byp = (BYPASS != 0) && hit;
    assign rs_data[i*XLEN +: XLEN] = (a == '0) ? '0 : (use_byp ? byp_d : regs_q[a]);
    assign rs_busy[i] = (a != '0) && busy[a] && !use_byp;
  end

endmodule

// File: tb/tb_id_rf_mp.sv
// Directed and random checks of id_rf_mp (bypass and non-bypass builds) against an array model.
`timescale 1ns/1ps
module tb_id_rf_mp;
  import rf_pkg::*;

  localparam int NRD = 2;
  localparam int NWR = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data_b, rs_data_n;
  logic [NRD-1:0]      rs_busy_b, rs_busy_n;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;

  int nvec = 0;
  int nerr = 0;

  logic [XLEN-1:0] m_mem  [NREG];
  bit              m_busy [NREG];

  always #5 clk = ~clk;

  id_rf_mp #(.NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid), .iss_rd(iss_rd)
  );

  id_rf_mp #(.NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data_n), .rs_busy(rs_busy_n),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid), .iss_rd(iss_rd)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Same-cycle write visible on read address a, highest port winning.
  function automatic bit wr_hit(input logic [AW-1:0] a, output logic [XLEN-1:0] d);
    bit h = 1'b0;
    d = '0;
    for (int j = 0; j < NWR; j++)
      if (we[j] && wr_addr[j*AW +: AW] == a) begin
        h = 1'b1;
        d = wr_data[j*XLEN +: XLEN];
      end
    return h;
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int i, input bit byp);
    logic [AW-1:0]   a = rs_addr[i*AW +: AW];
    logic [XLEN-1:0] d;
    if (a == 0) return '0;
    if (byp && wr_hit(a, d)) return d;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int i, input bit byp);
    logic [AW-1:0]   a = rs_addr[i*AW +: AW];
    logic [XLEN-1:0] d;
    if (a == 0) return 1'b0;
    if (byp && wr_hit(a, d)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < NRD; i++) begin
      chk($sformatf("%s.data_b[%0d]", tag, i), rs_data_b[i*XLEN +: XLEN], exp_data(i, 1'b1));
      chk($sformatf("%s.data_n[%0d]", tag, i), rs_data_n[i*XLEN +: XLEN], exp_data(i, 1'b0));
      chk($sformatf("%s.busy_b[%0d]", tag, i), {31'd0, rs_busy_b[i]}, {31'd0, exp_busy(i, 1'b1)});
      chk($sformatf("%s.busy_n[%0d]", tag, i), {31'd0, rs_busy_n[i]}, {31'd0, exp_busy(i, 1'b0)});
    end
  endtask

  // Advance the model with the current inputs, then take the clock edge.
  task automatic tick();
    if (rst_n) begin
      for (int j = 0; j < NWR; j++)
        if (we[j] && wr_addr[j*AW +: AW] != 0)
          m_mem[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      for (int j = 0; j < NWR; j++)
        if (we[j]) m_busy[wr_addr[j*AW +: AW]] = 1'b0;
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; wr_addr = '0; wr_data = '0; iss_valid = 1'b0; iss_rd = '0;
  endtask

  task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we[j] = 1'b1;
    wr_addr[j*AW +: AW] = a;
    wr_data[j*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rs_addr[i*AW +: AW] = a;
  endtask

  // Sweep all addresses while reset is held, well inside one clock phase.
  task automatic reset_sweep(input string tag);
    for (int r = 0; r < NREG; r += 2) begin
      set_rd(0, AW'(r));
      set_rd(1, AW'(r + 1));
      #0.2;
      for (int i = 0; i < NRD; i++) begin
        chk($sformatf("%s.data_b[%0d]", tag, r + i), rs_data_b[i*XLEN +: XLEN], '0);
        chk($sformatf("%s.data_n[%0d]", tag, r + i), rs_data_n[i*XLEN +: XLEN], '0);
        chk($sformatf("%s.busy_b[%0d]", tag, r + i), {31'd0, rs_busy_b[i]}, '0);
        chk($sformatf("%s.busy_n[%0d]", tag, r + i), {31'd0, rs_busy_n[i]}, '0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; rs_addr = '0;
    idle();
    model_clear();
    #1;
    reset_sweep("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write then read.
    set_wr(0, 5'd5, 32'hDEADBEEF);
    tick(); idle();
    set_rd(0, 5'd5); #1;
    chk("wr_rd_x5", rs_data_b[0 +: XLEN], 32'hDEADBEEF);
    check_all("wr_rd");

    // x0 ignores writes and issues.
    set_wr(1, REG_ZERO, 32'hFFFFFFFF); iss_valid = 1'b1; iss_rd = REG_ZERO;
    tick(); idle();
    set_rd(0, REG_ZERO); set_rd(1, REG_ZERO); #1;
    chk("x0_data", rs_data_b[0 +: XLEN], '0);
    chk("x0_busy", {31'd0, rs_busy_b[1]}, '0);
    check_all("x0");

    // Same-address conflict: port 1 wins.
    set_wr(0, 5'd7, 32'h1); set_wr(1, 5'd7, 32'h2);
    tick(); idle();
    set_rd(0, 5'd7); #1;
    chk("conflict_x7", rs_data_b[0 +: XLEN], 32'h2);
    check_all("conflict");

    // Bypass versus registered value.
    set_wr(0, 5'd3, 32'h11111111);
    tick(); idle();
    set_wr(0, 5'd3, 32'hA5A5A5A5); set_rd(1, 5'd3); #1;
    chk("byp_on", rs_data_b[XLEN +: XLEN], 32'hA5A5A5A5);
    chk("byp_off", rs_data_n[XLEN +: XLEN], 32'h11111111);
    check_all("bypass");
    tick(); idle();

    // Scoreboard set / set-beats-clear / clear.
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick(); idle();
    set_rd(0, 5'd9); #1;
    chk("sb_set", {31'd0, rs_busy_b[0]}, 32'd1);
    set_wr(0, 5'd9, 32'h99); iss_valid = 1'b1; iss_rd = 5'd9;
    tick(); idle(); #1;
    chk("sb_set_wins", {31'd0, rs_busy_n[0]}, 32'd1);
    set_wr(1, 5'd9, 32'h77); #1;
    chk("sb_clr_byp", {31'd0, rs_busy_b[0]}, 32'd0);
    chk("sb_clr_nobyp", {31'd0, rs_busy_n[0]}, 32'd1);
    tick(); idle(); #1;
    chk("sb_clr", {31'd0, rs_busy_n[0]}, 32'd0);
    check_all("sb");

    // Random traffic on a narrow address window so collisions are common.
    for (int n = 0; n < 300; n++) begin
      we        = NWR'($urandom);
      iss_valid = 1'($urandom);
      iss_rd    = AW'($urandom_range(0, 11));
      for (int j = 0; j < NWR; j++) begin
        wr_addr[j*AW +: AW]     = AW'($urandom_range(0, 11));
        wr_data[j*XLEN +: XLEN] = $urandom;
      end
      for (int i = 0; i < NRD; i++) set_rd(i, AW'($urandom_range(0, 11)));
      #1;
      check_all($sformatf("rnd%0d", n));
      tick();
    end

    // Reset asserted mid-cycle clears everything at once.
    idle();
    rst_n = 1'b0;
    model_clear();
    reset_sweep("rst1");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_rd(0, 5'd5); set_rd(1, 5'd9); #1;
    check_all("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
